// File: rtl/activation_pipe.sv
// activation_pipe: three-stage fixed-point activation unit.
// Per-sample modes: logsig, tansig (2*sig(2x)-1), purelin and relu.
// The sigmoid is a power-of-two-slope piecewise-linear curve built only from
// shifts and adds. A tag sideband travels with each sample. All stages advance
// together whenever the output register is empty or being drained.
module activation_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 10,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_mode,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_sat
);

  localparam logic [1:0] MODE_LOGSIG  = 2'd0;
  localparam logic [1:0] MODE_TANSIG  = 2'd1;
  localparam logic [1:0] MODE_PURELIN = 2'd2;

  localparam int ONE = 1 << FRAC_BITS;

  localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Segment breakpoints and offsets, rounded to FRAC_BITS.
  localparam logic [DATA_WIDTH-1:0] ONE_U   = DATA_WIDTH'(ONE);
  localparam logic [DATA_WIDTH-1:0] BRK_HI  = DATA_WIDTH'(5 * ONE);
  localparam logic [DATA_WIDTH-1:0] BRK_MID = DATA_WIDTH'((19 * ONE + 4) / 8);
  localparam logic [DATA_WIDTH-1:0] OFS_HI  = DATA_WIDTH'((27 * ONE + 16) / 32);
  localparam logic [DATA_WIDTH-1:0] OFS_MID = DATA_WIDTH'((5 * ONE + 4) / 8);
  localparam logic [DATA_WIDTH-1:0] OFS_LO  = DATA_WIDTH'((ONE + 1) / 2);

  logic adv;

  // Stage 1 registers
  logic                  vld1_reg;
  logic [DATA_WIDTH-1:0] x1_reg;
  logic [DATA_WIDTH-1:0] a1_reg;
  logic                  s1_reg;
  logic                  sat1_reg;
  logic [1:0]            mode1_reg;
  logic [TAG_WIDTH-1:0]  tag1_reg;

  // Stage 2 registers
  logic                  vld2_reg;
  logic [DATA_WIDTH-1:0] x2_reg;
  logic [DATA_WIDTH-1:0] p2_reg;
  logic                  s2_reg;
  logic                  sat2_reg;
  logic [1:0]            mode2_reg;
  logic [TAG_WIDTH-1:0]  tag2_reg;

  // Stage 3 (output) registers
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [TAG_WIDTH-1:0]  out_tag_reg;
  logic                  out_sat_reg;

  // Combinational next-state values
  logic [DATA_WIDTH:0]   dbl_next;
  logic [DATA_WIDTH-1:0] z1_next;
  logic [DATA_WIDTH-1:0] a1_next;
  logic                  sat1_next;
  logic [DATA_WIDTH-1:0] p2_next;
  logic                  sat2_next;
  logic [DATA_WIDTH-1:0] sig3_next;
  logic [DATA_WIDTH+1:0] tan3_wide;
  logic [DATA_WIDTH-1:0] out_data_next;
  logic                  out_sat_next;

  assign adv       = out_ready | ~out_valid_reg;
  assign in_ready  = adv;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_tag   = out_tag_reg;
  assign out_sat   = out_sat_reg;

  // Stage 1: optional saturating doubling for tansig, then magnitude and sign.
  assign dbl_next = {in_data, 1'b0};
  always_comb begin
    z1_next   = in_data;
    sat1_next = 1'b0;
    if (in_mode == MODE_TANSIG) begin
      if (dbl_next[DATA_WIDTH] != dbl_next[DATA_WIDTH-1]) begin
        z1_next   = dbl_next[DATA_WIDTH] ? MIN_VAL : MAX_VAL;
        sat1_next = 1'b1;
      end else begin
        z1_next = dbl_next[DATA_WIDTH-1:0];
      end
    end
    if (z1_next == MIN_VAL) begin
      a1_next = MAX_VAL;
    end else if (z1_next[DATA_WIDTH-1]) begin
      a1_next = -z1_next;
    end else begin
      a1_next = z1_next;
    end
  end

  // Stage 2: piecewise-linear sigmoid on the magnitude; breakpoints go upward.
  always_comb begin
    sat2_next = sat1_reg;
    if (a1_reg >= BRK_HI) begin
      p2_next   = ONE_U;
      sat2_next = 1'b1;
    end else if (a1_reg >= BRK_MID) begin
      p2_next = (a1_reg >> 5) + OFS_HI;
    end else if (a1_reg >= ONE_U) begin
      p2_next = (a1_reg >> 3) + OFS_MID;
    end else begin
      p2_next = (a1_reg >> 2) + OFS_LO;
    end
  end

  // Stage 3: mirror for negative inputs, then select the requested activation.
  assign sig3_next = s2_reg ? (ONE_U - p2_reg) : p2_reg;
  assign tan3_wide = {1'b0, sig3_next, 1'b0} - {2'b00, ONE_U};
  always_comb begin
    out_data_next = sig3_next;
    out_sat_next  = sat2_reg;
    case (mode2_reg)
      MODE_LOGSIG: begin
        out_data_next = sig3_next;
      end
      MODE_TANSIG: begin
        out_data_next = tan3_wide[DATA_WIDTH-1:0];
      end
      MODE_PURELIN: begin
        out_data_next = x2_reg;
        out_sat_next  = 1'b0;
      end
      default: begin
        out_data_next = x2_reg[DATA_WIDTH-1] ? '0 : x2_reg;
        out_sat_next  = 1'b0;
      end
    endcase
  end

  // Valid chain and output register: cleared by reset, held when stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_reg      <= 1'b0;
      vld2_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_tag_reg   <= '0;
      out_sat_reg   <= 1'b0;
    end else if (adv) begin
      vld1_reg      <= in_valid;
      vld2_reg      <= vld1_reg;
      out_valid_reg <= vld2_reg;
      out_data_reg  <= out_data_next;
      out_tag_reg   <= tag2_reg;
      out_sat_reg   <= out_sat_next;
    end
  end

  // Internal datapath registers: contents only matter where the valid bit is set.
  always_ff @(posedge clk) begin
    if (adv) begin
      x1_reg    <= in_data;
      a1_reg    <= a1_next;
      s1_reg    <= z1_next[DATA_WIDTH-1];
      sat1_reg  <= sat1_next;
      mode1_reg <= in_mode;
      tag1_reg  <= in_tag;
      x2_reg    <= x1_reg;
      p2_reg    <= p2_next;
      s2_reg    <= s1_reg;
      sat2_reg  <= sat2_next;
      mode2_reg <= mode1_reg;
      tag2_reg  <= tag1_reg;
    end
  end

endmodule

// File: tb/tb_activation_pipe.sv
// Directed bench for activation_pipe (Q5.10 defaults).
module tb_activation_pipe;

  localparam int DW = 16;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    in_mode;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic          out_sat;

  int checks = 0;
  int errors = 0;

  activation_pipe #(.DATA_WIDTH(DW), .FRAC_BITS(10), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int d, input logic [1:0] m, input int t);
    in_valid = v;
    in_data  = DW'(d);
    in_mode  = m;
    in_tag   = TW'(t);
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b0, 0, 2'd0, 0);
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got %0d exp 0", out_data); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_tag got %0d exp 0", out_tag); end
    checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %0b exp 0", out_sat); end
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle got %0b exp 0", out_valid); end
  endtask

  task automatic test_logsig();
    int xs[5] = '{0, 1024, -1024, 6144, -6144};
    int es[5] = '{512, 768, 256, 1024, 0};
    logic ss[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int j = 0; j < 8; j++) begin
      if (j >= 3) begin
        $display("tx logsig tag=%0d data=%0d sat=%0b", out_tag, $signed(out_data), out_sat);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL logsig_valid[%0d] got %0b exp 1", j-3, out_valid); end
        checks++; if (int'($signed(out_data)) !== es[j-3]) begin errors++; $display("FAIL logsig_data[%0d] got %0d exp %0d", j-3, $signed(out_data), es[j-3]); end
        checks++; if (out_tag !== TW'(j-2)) begin errors++; $display("FAIL logsig_tag[%0d] got %0d exp %0d", j-3, out_tag, j-2); end
        checks++; if (out_sat !== ss[j-3]) begin errors++; $display("FAIL logsig_sat[%0d] got %0b exp %0b", j-3, out_sat, ss[j-3]); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL logsig_latency[%0d] got %0b exp 0", j, out_valid); end
      end
      if (j < 5) drive(1'b1, xs[j], 2'd0, j+1); else drive(1'b0, 0, 2'd0, 0);
      tick();
    end
  endtask

  task automatic test_tansig();
    int xs[4] = '{512, -3072, 0, 20000};
    int es[4] = '{512, -1024, 0, 1024};
    logic ss[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int j = 0; j < 7; j++) begin
      if (j >= 3) begin
        $display("tx tansig tag=%0d data=%0d sat=%0b", out_tag, $signed(out_data), out_sat);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tansig_valid[%0d] got %0b exp 1", j-3, out_valid); end
        checks++; if (int'($signed(out_data)) !== es[j-3]) begin errors++; $display("FAIL tansig_data[%0d] got %0d exp %0d", j-3, $signed(out_data), es[j-3]); end
        checks++; if (out_tag !== TW'(j+37)) begin errors++; $display("FAIL tansig_tag[%0d] got %0d exp %0d", j-3, out_tag, j+37); end
        checks++; if (out_sat !== ss[j-3]) begin errors++; $display("FAIL tansig_sat[%0d] got %0b exp %0b", j-3, out_sat, ss[j-3]); end
      end
      if (j < 4) drive(1'b1, xs[j], 2'd1, j+40); else drive(1'b0, 0, 2'd0, 0);
      tick();
    end
  endtask

  task automatic test_linear();
    int xs[4] = '{-300, -300, 700, 700};
    logic [1:0] ms[4] = '{2'd2, 2'd3, 2'd2, 2'd3};
    int es[4] = '{-300, 0, 700, 700};
    for (int j = 0; j < 7; j++) begin
      if (j >= 3) begin
        $display("tx linear tag=%0d data=%0d sat=%0b", out_tag, $signed(out_data), out_sat);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL linear_valid[%0d] got %0b exp 1", j-3, out_valid); end
        checks++; if (int'($signed(out_data)) !== es[j-3]) begin errors++; $display("FAIL linear_data[%0d] got %0d exp %0d", j-3, $signed(out_data), es[j-3]); end
        checks++; if (out_tag !== TW'(j+77)) begin errors++; $display("FAIL linear_tag[%0d] got %0d exp %0d", j-3, out_tag, j+77); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL linear_sat[%0d] got %0b exp 0", j-3, out_sat); end
      end
      if (j < 4) drive(1'b1, xs[j], ms[j], j+80); else drive(1'b0, 0, 2'd0, 0);
      tick();
    end
  endtask

  // 2432 sits on the upper segment: (2432>>5)+864 = 940.
  task automatic test_boundary();
    int xs[4] = '{2432, 2431, 5120, 5119};
    int es[4] = '{940, 943, 1024, 1023};
    logic ss[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int j = 0; j < 7; j++) begin
      if (j >= 3) begin
        $display("tx boundary tag=%0d data=%0d sat=%0b", out_tag, $signed(out_data), out_sat);
        checks++; if (int'($signed(out_data)) !== es[j-3]) begin errors++; $display("FAIL boundary_data[%0d] got %0d exp %0d", j-3, $signed(out_data), es[j-3]); end
        checks++; if (out_sat !== ss[j-3]) begin errors++; $display("FAIL boundary_sat[%0d] got %0b exp %0b", j-3, out_sat, ss[j-3]); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL boundary_valid[%0d] got %0b exp 1", j-3, out_valid); end
      end
      if (j < 4) drive(1'b1, xs[j], 2'd0, j+100); else drive(1'b0, 0, 2'd0, 0);
      tick();
    end
  endtask

  task automatic test_backpressure();
    int xs[10] = '{0, 256, 512, 768, 1024, 1536, 2048, 3072, 4096, -512};
    int es[10] = '{512, 576, 640, 704, 768, 832, 896, 960, 992, 384};
    int k = 0;
    int i = 0;
    int c = 0;
    logic stall;
    logic acc;
    while (k < 10 && c < 60) begin
      stall = (c >= 4 && c <= 7);
      out_ready = ~stall;
      if (i < 10) drive(1'b1, xs[i], 2'd0, 10+i); else drive(1'b0, 0, 2'd0, 0);
      #1;
      checks++; if (in_ready !== ~stall) begin errors++; $display("FAIL bp_ready[c%0d] got %0b exp %0b", c, in_ready, ~stall); end
      acc = in_valid & in_ready;
      if (out_valid === 1'b1) begin
        $display("tx bp c=%0d tag=%0d data=%0d ready=%0b", c, out_tag, $signed(out_data), out_ready);
        checks++; if (int'($signed(out_data)) !== es[k]) begin errors++; $display("FAIL bp_data[%0d] got %0d exp %0d", k, $signed(out_data), es[k]); end
        checks++; if (out_tag !== TW'(10+k)) begin errors++; $display("FAIL bp_tag[%0d] got %0d exp %0d", k, out_tag, 10+k); end
        if (out_ready) k++;
      end
      if (acc) i++;
      tick();
      c++;
    end
    checks++; if (k != 10) begin errors++; $display("FAIL bp_count got %0d exp 10", k); end
    checks++; if (i != 10) begin errors++; $display("FAIL bp_accepted got %0d exp 10", i); end
    out_ready = 1'b1;
    drive(1'b0, 0, 2'd0, 0);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b exp 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 1024, 2'd0, 33); tick();
    drive(1'b1, -1024, 2'd0, 34); tick();
    drive(1'b1, 0, 2'd0, 35); rst = 1'b1; tick();
    rst = 1'b0;
    drive(1'b0, 0, 2'd0, 0);
    for (int j = 0; j < 4; j++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale[%0d] got %0b exp 0", j, out_valid); end
      tick();
    end
    for (int j = 0; j < 4; j++) begin
      if (j == 3) begin
        $display("tx midrst tag=%0d data=%0d sat=%0b", out_tag, $signed(out_data), out_sat);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_valid got %0b exp 1", out_valid); end
        checks++; if (int'($signed(out_data)) !== 896) begin errors++; $display("FAIL midrst_data got %0d exp 896", $signed(out_data)); end
        checks++; if (out_tag !== TW'(85)) begin errors++; $display("FAIL midrst_tag got %0d exp 85", out_tag); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_latency[%0d] got %0b exp 0", j, out_valid); end
      end
      if (j == 0) drive(1'b1, 2048, 2'd0, 85); else drive(1'b0, 0, 2'd0, 0);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_logsig();
    test_tansig();
    test_linear();
    test_boundary();
    test_backpressure();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
